// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares the framebuffer RAM between the CPU bus
// and scanout, prefetching pixel words into a small FIFO for vga.
module vga_vram_arbiter #(
  parameter int H_WORDS = 50,
  parameter int V_LINES = 601,
  parameter int ADDR_W  = 15,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_data,
  input  logic              v_sync,
  output logic [15:0]       pixel_data,
  output logic              underflow,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [15:0]       cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [ADDR_W-1:0] SP_LAST =
    ADDR_W'(H_WORDS * V_LINES - 1);
  localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] OCC_LOW  = CW'(2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_VID  = 2'd1;
  localparam logic [1:0] S_CPU  = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  logic [1:0]        state;
  logic              issue;
  logic              cpu_rd;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] sp_cur;
  logic [ADDR_W-1:0] sp_inc;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     occ_nx;
  logic              inf;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [15:0]       mem [DEPTH];
  logic              vs_r;
  logic              vs_rr;
  logic              resync;
  logic              push;
  logic              pop;
  logic              arb;
  logic              urgent;
  logic              room;
  logic              go_vid;
  logic              go_cpu;

  assign resync = vs_rr & ~vs_r;
  assign pop    = new_data & (occ != '0);
  assign push   = (state == S_VID) & ~issue
                & inf & ~resync;

  assign sp_cur = resync ? '0 : sp;
  assign sp_inc = (sp_cur == SP_LAST) ? '0
                : sp_cur + ADDR_W'(1);

  // FIFO occupancy after this cycle's flush, push and pop
  always_comb begin
    occ_nx = occ;
    if (resync) occ_nx = '0;
    else occ_nx = occ + CW'(push) - CW'(pop);
  end

  // arbitrate in IDLE and in the video data cycle
  assign arb    = (state == S_IDLE)
                | ((state == S_VID) & ~issue);
  assign urgent = occ_nx < OCC_LOW;
  assign room   = occ_nx < OCC_FULL;
  assign go_vid = arb & (urgent | (~cpu_req & room));
  assign go_cpu = arb & ~urgent & cpu_req;

  assign pixel_data = (occ == '0) ? '0 : mem[rd_ptr];

  // sequencer: RAM strobes, CPU completion and state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      issue     <= 1'b0;
      cpu_rd    <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      ram_en  <= 1'b0;
      ram_we  <= 1'b0;
      cpu_ack <= 1'b0;
      issue   <= 1'b0;
      if (go_vid) begin
        state    <= S_VID;
        issue    <= 1'b1;
        ram_en   <= 1'b1;
        ram_addr <= sp_cur;
      end else if (go_cpu) begin
        state     <= S_CPU;
        issue     <= 1'b1;
        cpu_rd    <= ~cpu_we;
        ram_en    <= 1'b1;
        ram_we    <= cpu_we;
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
      end else begin
        unique case (state)
          S_IDLE: state <= S_IDLE;
          S_VID: begin
            if (!issue) state <= S_IDLE;
          end
          S_CPU: begin
            if (!issue) begin
              if (cpu_rd) cpu_rdata <= ram_rdata;
              cpu_ack <= 1'b1;
              state   <= S_ACK;
            end
          end
          S_ACK: state <= S_IDLE;
        endcase
      end
    end
  end

  // scan pointer, FIFO bookkeeping, vsync edge and underflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp        <= '0;
      occ       <= '0;
      inf       <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      vs_r      <= 1'b0;
      vs_rr     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      vs_r  <= v_sync;
      vs_rr <= vs_r;
      occ   <= occ_nx;
      sp    <= go_vid ? sp_inc : sp_cur;
      if (new_data && occ == '0) underflow <= 1'b1;
      if (go_vid) inf <= 1'b1;
      else if (resync || push) inf <= 1'b0;
      if (resync) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // pixel word storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ram_rdata;
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed checks of fetch order, CPU latency,
// pop timing, wrap, vsync resync and sticky underflow.
module tb_vga_vram_arbiter;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          new_data = 1'b0;
  logic          v_sync = 1'b1;
  logic [15:0]   pixel_data;
  logic          underflow;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [15:0]   cpu_wdata = '0;
  logic          cpu_ack;
  logic [15:0]   cpu_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata = '0;

  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  int fq[$];
  logic [15:0] wr_mem [int];
  bit t3_done;

  vga_vram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .new_data   (new_data),
    .v_sync     (v_sync),
    .pixel_data (pixel_data),
    .underflow  (underflow),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 257 + 16'h1357);
  endfunction

  // synchronous RAM: background pattern unless written
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) wr_mem[int'(ram_addr)] = ram_wdata;
      else if (wr_mem.exists(int'(ram_addr)))
        ram_rdata <= wr_mem[int'(ram_addr)];
      else ram_rdata <= pat(int'(ram_addr));
    end
  end

  // log every RAM access; video ones by address
  always @(negedge clk) begin
    if (ram_en) begin
      en_cnt++;
      if (!(cpu_req && ram_addr == cpu_addr))
        fq.push_back(int'(ram_addr));
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    new_data = 1'b0;
    cpu_req = 1'b0;
    v_sync = 1'b1;
    tick(3);
    reset = 1'b1;
  endtask

  task automatic cpu_xfer(input logic we,
                          input logic [AW-1:0] a,
                          input logic [15:0] d,
                          output int lat,
                          output logic ok,
                          output logic [15:0] rd);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!cpu_ack && lat < 30);
    ok = cpu_ack;
    rd = cpu_rdata;
    cpu_req = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int b, be, lat, n, err, naks, k, e;
    logic ok;
    logic [15:0] rd;

    // reset values
    reset = 1'b0;
    tick(3);
    chk("rst pixel", pixel_data, 0);
    chk("rst uflow", underflow, 0);
    chk("rst ack", cpu_ack, 0);
    chk("rst rdata", cpu_rdata, 0);
    chk("rst en", ram_en, 0);
    chk("rst addr", ram_addr, 0);
    b = fq.size();
    be = en_cnt;
    reset = 1'b1;

    // test 1: idle fill, first word latency, 4 fetches
    tick(2);
    chk("t1 lat2", pixel_data, 0);
    tick();
    chk("t1 lat3", pixel_data, pat(0));
    tick(40);
    chk("t1 en cnt", en_cnt - be, 4);
    for (int i = 0; i < 4; i++)
      chk("t1 addr", fq[b + i], i);
    chk("t1 head", pixel_data, pat(0));
    chk("t1 uflow", underflow, 0);
    new_data = 1'b1;
    tick();
    new_data = 1'b0;
    chk("t1 pop", pixel_data, pat(1));

    // test 2: full FIFO, CPU write then read
    tick(20);
    be = en_cnt;
    cpu_xfer(1'b1, AW'(16'h1234), 16'hBEEF, lat, ok, rd);
    chk("t2 wr lat", lat, 3);
    tick();
    chk("t2 ack drop", cpu_ack, 0);
    cpu_xfer(1'b0, AW'(16'h1234), 16'h0, lat, ok, rd);
    chk("t2 rd lat", lat, 3);
    chk("t2 rdata", rd, 16'hBEEF);
    tick(3);
    chk("t2 rd hold", cpu_rdata, 16'hBEEF);
    chk("t2 en cnt", en_cnt - be, 2);

    // test 3: paced pops under continuous CPU load
    do_reset();
    b = fq.size();
    t3_done = 1'b0;
    naks = 0;
    k = 0;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          tick(15);
          chk("t3 head", pixel_data, pat(i));
          new_data = 1'b1;
          tick();
          new_data = 1'b0;
        end
        t3_done = 1'b1;
      end
      begin
        while (!t3_done) begin
          cpu_xfer(1'b1, AW'(16'h6000 + k),
                   16'(k * 31 + 7), lat, ok, rd);
          if (!ok) naks++;
          cpu_xfer(1'b0, AW'(16'h6000 + k),
                   16'h0, lat, ok, rd);
          if (!ok) naks++;
          chk("t3 rdata", rd, 16'(k * 31 + 7));
          k++;
        end
      end
    join
    tick(40);
    chk("t3 uflow", underflow, 0);
    chk("t3 naks", naks, 0);
    n = fq.size() - b;
    chk("t3 fetches", n, 54);
    err = 0;
    for (int i = 0; i < n; i++)
      if (fq[b + i] != i) err++;
    chk("t3 order", err, 0);

    // test 4: scan pointer wrap at the last frame word
    do_reset();
    b = fq.size();
    new_data = 1'b1;
    n = 0;
    while (fq.size() - b < 30051 && n < 80000) begin
      tick();
      n++;
    end
    new_data = 1'b0;
    n = fq.size() - b;
    chk("t4 count", n >= 30051, 1);
    err = 0;
    e = 0;
    for (int i = 0; i < n; i++) begin
      if (fq[b + i] != e) err++;
      e = (e == 30049) ? 0 : e + 1;
    end
    chk("t4 seq", err, 0);
    chk("t4 last", (n > 30049) ? fq[b + 30049] : -1, 30049);
    chk("t4 wrap", (n > 30050) ? fq[b + 30050] : -1, 0);

    // test 5: vsync falls right after a video issue
    do_reset();
    b = fq.size();
    tick();
    v_sync = 1'b0;
    tick(2);
    chk("t5 drop", pixel_data, 0);
    tick(40);
    chk("t5 fetches", fq.size() - b, 5);
    chk("t5 refetch0", fq[b + 1], 0);
    chk("t5 refetch3", fq[b + 4], 3);
    chk("t5 head", pixel_data, pat(0));
    v_sync = 1'b1;
    tick(3);
    b = fq.size();
    v_sync = 1'b0;
    tick();
    chk("t5 pre flush", pixel_data, pat(0));
    tick();
    chk("t5 flush", pixel_data, 0);
    tick(40);
    chk("t5 restart", fq[b], 0);
    v_sync = 1'b1;

    // test 6: pops before any data, sticky underflow
    do_reset();
    new_data = 1'b1;
    tick();
    chk("t6 uf set", underflow, 1);
    tick();
    new_data = 1'b0;
    tick(40);
    chk("t6 uf stay", underflow, 1);
    chk("t6 fifo", pixel_data, pat(0));
    reset = 1'b0;
    tick();
    chk("t6 uf clr", underflow, 0);
    reset = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
